// File: rtl/cam_capture_bram.sv
// ---------------------------------------------------------------------------
// cam_capture_bram
//   Turns an 8-bit RGB565 camera stream (high byte first) into 16-bit pixel
//   writes for a frame-buffer BRAM. All logic runs in the camera's pclk
//   domain. Each frame starts on a falling vsync edge and ends on a rising
//   vsync edge. Each line is framed by href.
//
// Ports
//   pclk, rst     : pixel clock; asynchronous active-high reset
//   cam_vsync     : high during vertical blanking
//   cam_href      : high while line bytes are valid
//   cam_data[7:0] : camera byte
//   capture_en    : level enable for continuous capture
//   frame_addr    : BRAM write address (17 bits)
//   frame_pixel   : assembled pixel {R,G,B} 5:6:5
//   frame_we      : one-cycle write strobe per pixel
//   frame_done    : one-cycle pulse when a captured frame ends
//   frame_err     : geometry error in the frame that last completed
//   line_cnt      : number of lines completed so far in this frame
// ---------------------------------------------------------------------------
module cam_capture_bram #(
  parameter int H_PIXELS  = 320,
  parameter int V_LINES   = 240,
  parameter int ADDR_LAST = 76799
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        capture_en,
  output logic [16:0] frame_addr,
  output logic [15:0] frame_pixel,
  output logic        frame_we,
  output logic        frame_done,
  output logic        frame_err,
  output logic [7:0]  line_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SOF, S_CAPTURE} state_t;

  state_t      r_state, w_next;
  logic        r_vsync_q, r_href_q;
  logic        r_phase;        // 1: high byte held, waiting for the low byte
  logic [7:0]  r_hi;
  logic [15:0] r_pix_cnt;      // saturating, so runaway lines cannot wrap
  logic        r_full;         // the ADDR_LAST write is done; drop the rest
  logic [16:0] r_addr;
  logic [15:0] r_pixel;
  logic        r_we, r_done, r_err;
  logic [7:0]  r_line;

  logic w_vs_rise, w_vs_fall, w_hr_rise, w_hr_fall;
  logic w_sof, w_cap, w_eof;
  logic w_byte_hi, w_byte_lo;
  logic [7:0] w_line_inc, w_line_next;
  logic w_line_bad;

  assign w_vs_rise = ~r_vsync_q &  cam_vsync;
  assign w_vs_fall =  r_vsync_q & ~cam_vsync;
  assign w_hr_rise = ~r_href_q  &  cam_href;
  assign w_hr_fall =  r_href_q  & ~cam_href;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (capture_en) w_next = S_WAIT_SOF;
      S_WAIT_SOF: if (w_vs_fall)  w_next = S_CAPTURE;
      // A frame that has started always runs to its end, even if capture_en
      // drops. capture_en only decides whether we re-arm afterwards.
      S_CAPTURE:  if (w_vs_rise)  w_next = capture_en ? S_WAIT_SOF : S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: control decode ----------------
  always_comb begin
    w_sof = 1'b0;
    w_cap = 1'b0;
    w_eof = 1'b0;
    case (r_state)
      S_WAIT_SOF: w_sof = w_vs_fall;
      S_CAPTURE: begin
        w_cap = 1'b1;
        w_eof = w_vs_rise;
      end
      default: ;
    endcase
  end

  // The byte on the href rising edge is always a high byte. Any phase left
  // over from an earlier line does not matter.
  assign w_byte_hi = cam_href & (w_hr_rise | ~r_phase);
  assign w_byte_lo = cam_href & ~w_hr_rise & r_phase;

  assign w_line_inc  = (r_line == 8'hFF) ? r_line : r_line + 8'd1;
  // A line that ends on the same edge as the frame still counts toward the
  // line-count check.
  assign w_line_next = (w_cap & w_hr_fall) ? w_line_inc : r_line;
  assign w_line_bad  = (r_pix_cnt != 16'(H_PIXELS)) | r_phase;

  // ---------------- datapath ----------------
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_vsync_q <= 1'b0;
      r_href_q  <= 1'b0;
      r_phase   <= 1'b0;
      r_hi      <= '0;
      r_pix_cnt <= '0;
      r_full    <= 1'b0;
      r_addr    <= '0;
      r_pixel   <= '0;
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_line    <= '0;
    end else begin
      r_vsync_q <= cam_vsync;
      r_href_q  <= cam_href;
      r_we      <= 1'b0;
      r_done    <= w_eof;

      // The address advances as each write strobe retires. It sticks at the
      // last location, and from then on any further pixels are suppressed.
      if (r_we) begin
        if (r_addr == 17'(ADDR_LAST)) r_full <= 1'b1;
        else                          r_addr <= r_addr + 17'd1;
      end

      if (w_sof) begin
        r_addr    <= '0;
        r_line    <= '0;
        r_pix_cnt <= '0;
        r_phase   <= 1'b0;
        r_err     <= 1'b0;
        r_full    <= 1'b0;
      end else if (w_cap) begin
        if (w_hr_rise) r_pix_cnt <= '0;

        if (w_byte_hi) begin
          r_hi    <= cam_data;
          r_phase <= 1'b1;
        end else if (w_byte_lo) begin
          r_phase <= 1'b0;
          if (r_pix_cnt != 16'hFFFF) r_pix_cnt <= r_pix_cnt + 16'd1;
          if (r_full) begin
            r_err <= 1'b1;
          end else begin
            r_pixel <= {r_hi, cam_data};
            r_we    <= 1'b1;
          end
        end

        // On an odd byte count the last high byte is simply dropped.
        if (w_hr_fall) begin
          r_line  <= w_line_inc;
          r_phase <= 1'b0;
          if (w_line_bad) r_err <= 1'b1;
        end

        if (w_eof && (w_line_next != 8'(V_LINES))) r_err <= 1'b1;
      end
    end
  end

  assign frame_addr  = r_addr;
  assign frame_pixel = r_pixel;
  assign frame_we    = r_we;
  assign frame_done  = r_done;
  assign frame_err   = r_err;
  assign line_cnt    = r_line;

endmodule

// File: tb/tb_cam_capture_bram.sv
// Scoreboard bench for cam_capture_bram. It uses a reduced geometry
// (16x8, last address 127). The reference model works frame by frame.
// For every line it drives, it works out which pixel writes should appear
// and what the end-of-frame status should be. A separate monitor compares
// what the DUT presents against those queues.
module tb_cam_capture_bram;
  localparam int H  = 16;
  localparam int V  = 8;
  localparam int AL = H * V - 1;

  logic        pclk = 1'b0;
  logic        rst;
  logic        cam_vsync, cam_href, capture_en;
  logic [7:0]  cam_data;
  logic [16:0] frame_addr;
  logic [15:0] frame_pixel;
  logic        frame_we, frame_done, frame_err;
  logic [7:0]  line_cnt;

  cam_capture_bram #(.H_PIXELS(H), .V_LINES(V), .ADDR_LAST(AL)) dut (
    .pclk(pclk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .capture_en(capture_en), .frame_addr(frame_addr),
    .frame_pixel(frame_pixel), .frame_we(frame_we), .frame_done(frame_done),
    .frame_err(frame_err), .line_cnt(line_cnt)
  );

  always #5 pclk = ~pclk;

  typedef struct packed { logic [16:0] a; logic [15:0] p; } wr_t;
  typedef struct packed { logic err; logic [7:0] lines; } done_t;

  wr_t   wq[$];
  done_t dq[$];
  int    errors = 0;
  int    checks = 0;

  // frame-level reference state
  bit m_cap;
  int m_idx;
  bit m_err;
  int m_lines;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  wr_t   mw;
  done_t md;
  always @(negedge pclk) begin
    if (!rst) begin
      if (frame_we) begin
        if (wq.size() == 0) check("spurious_we", 32'd1, 32'd0);
        else begin
          mw = wq.pop_front();
          check("wr_addr",  32'(frame_addr),  32'(mw.a));
          check("wr_pixel", 32'(frame_pixel), 32'(mw.p));
        end
      end
      if (frame_done) begin
        if (dq.size() == 0) check("spurious_done", 32'd1, 32'd0);
        else begin
          md = dq.pop_front();
          check("done_err",   32'(frame_err), 32'(md.err));
          check("done_lines", 32'(line_cnt),  32'(md.lines));
        end
      end
    end
  end

  // ---------------- driver + model ----------------
  task automatic push_done();
    done_t d;
    d.err   = m_err | (m_lines != V);
    d.lines = (m_lines > 255) ? 8'd255 : 8'(m_lines);
    if (m_cap) dq.push_back(d);
  endtask

  task automatic frame_start(input bit en);
    capture_en = en;
    cam_vsync  = 1'b1;
    repeat (3) @(posedge pclk);
    #1 cam_vsync = 1'b0;
    m_cap = en; m_idx = 0; m_err = 0; m_lines = 0;
    repeat (2) @(posedge pclk);
  endtask

  // nbytes bytes on one href pulse; fixed=1 sends F8,1F pairs.
  // fin=1 raises vsync on the same cycle href falls.
  task automatic line(input int nbytes, input bit fixed, input bit fin);
    logic [7:0] d[$];
    wr_t w;
    for (int b = 0; b < nbytes; b++)
      d.push_back(fixed ? ((b % 2) ? 8'h1F : 8'hF8) : 8'($urandom));
    if (m_cap) begin
      for (int j = 0; j < nbytes / 2; j++) begin
        if (m_idx <= AL) begin
          w.a = 17'(m_idx);
          w.p = {d[2*j], d[2*j+1]};
          wq.push_back(w);
        end else m_err = 1;
        m_idx++;
      end
      if (nbytes != 2 * H) m_err = 1;
      m_lines++;
    end
    for (int b = 0; b < nbytes; b++) begin
      @(posedge pclk); #1;
      cam_href = 1'b1;
      cam_data = d[b];
    end
    @(posedge pclk); #1;
    cam_href = 1'b0;
    if (fin) begin
      cam_vsync = 1'b1;
      push_done();
    end
    repeat ($urandom_range(2, 5)) @(posedge pclk);
  endtask

  task automatic frame_end();
    #1 cam_vsync = 1'b1;
    push_done();
    repeat (3) @(posedge pclk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"},  32'(frame_addr),  32'd0);
    check({tag, "_pixel"}, 32'(frame_pixel), 32'd0);
    check({tag, "_we"},    32'(frame_we),    32'd0);
    check({tag, "_done"},  32'(frame_done),  32'd0);
    check({tag, "_err"},   32'(frame_err),   32'd0);
    check({tag, "_lines"}, 32'(line_cnt),    32'd0);
  endtask

  initial begin
    rst = 1'b1; cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'h00; capture_en = 1'b0;
    m_cap = 0; m_idx = 0; m_err = 0; m_lines = 0;
    repeat (3) @(posedge pclk);
    #1 check_zero("reset");
    rst = 1'b0;

    // full frame, constant magenta pixels
    frame_start(1);
    for (int l = 0; l < V; l++) line(2 * H, 1, 0);
    frame_end();

    // random data; the last href fall coincides with the vsync rise
    frame_start(1);
    for (int l = 0; l < V; l++) line(2 * H, 0, l == V - 1);
    repeat (3) @(posedge pclk);

    // one short line; later lines continue at consecutive addresses
    frame_start(1);
    for (int l = 0; l < V; l++) line((l == 3) ? 2 * H - 2 : 2 * H, 0, 0);
    frame_end();

    // one line too many: writes stop at the last address
    frame_start(1);
    for (int l = 0; l < V + 1; l++) line(2 * H, 0, 0);
    frame_end();

    // odd byte count in one line
    frame_start(1);
    for (int l = 0; l < V; l++) line((l == 2) ? 2 * H + 1 : 2 * H, 0, 0);
    frame_end();

    // one line too few
    frame_start(1);
    for (int l = 0; l < V - 1; l++) line(2 * H, 0, 0);
    frame_end();

    // enable dropped mid-frame: this frame completes, the next is ignored
    frame_start(1);
    for (int l = 0; l < V; l++) begin
      if (l == 3) capture_en = 1'b0;
      line(2 * H, 0, 0);
    end
    frame_end();
    frame_start(0);
    for (int l = 0; l < V; l++) line(2 * H, 0, 0);
    frame_end();

    // reset mid-frame: outputs clear at once; rest of frame is ignored
    frame_start(1);
    for (int l = 0; l < 4; l++) line(2 * H, 0, 0);
    #1 rst = 1'b1;
    #1 check_zero("midrst");
    @(posedge pclk); #1 rst = 1'b0;
    m_cap = 0;
    for (int l = 4; l < V; l++) line(2 * H, 0, 0);
    frame_end();

    // capture resumes from address 0 on the next frame
    frame_start(1);
    for (int l = 0; l < V; l++) line(2 * H, 0, 0);
    frame_end();

    // bounded drain
    for (int i = 0; i < 200 && (wq.size() != 0 || dq.size() != 0); i++) @(posedge pclk);
    repeat (2) @(posedge pclk);
    check("pending_writes", 32'(wq.size()), 32'd0);
    check("pending_done",   32'(dq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cam_capture_bram.md
CAM_CAPTURE_BRAM -- requirements
Module: cam_capture_bram

Interface
REQ-001 Parameter H_PIXELS, default 320, pixels per captured line.
REQ-002 Parameter V_LINES, default 240, lines per captured frame.
REQ-003 Parameter ADDR_LAST, default 76799, last valid frame-buffer address (H_PIXELS*V_LINES-1).
REQ-004 pclk  in  1  camera pixel clock; sole clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cam_vsync  in  1  camera vertical sync, high during vertical blanking.
REQ-007 cam_href  in  1  camera line-valid, high while line bytes are presented.
REQ-008 cam_data  in  8  camera byte, RGB565, high byte first.
REQ-009 capture_en  in  1  continuous-capture enable, level-sensitive.
REQ-010 frame_addr  out  17  frame-buffer write address.
REQ-011 frame_pixel  out  16  assembled RGB565 pixel {R[15:11],G[10:5],B[4:0]}.
REQ-012 frame_we  out  1  frame-buffer write strobe, one pclk per pixel.
REQ-013 frame_done  out  1  one-cycle pulse at end of each captured frame.
REQ-014 frame_err  out  1  geometry error flag for last completed frame.
REQ-015 line_cnt  out  8  completed lines in current frame.

Function
REQ-016 States: IDLE, WAIT_SOF, CAPTURE; registered previous values vsync_q, href_q drive edge detection.
REQ-017 IDLE: capture_en=1 -> WAIT_SOF; otherwise stay.
REQ-018 WAIT_SOF: vsync falling edge (vsync_q=1, cam_vsync=0) -> CAPTURE, clearing frame_addr, line_cnt, pixel count, byte phase and frame_err.
REQ-019 CAPTURE, cam_href=1, byte phase 0: latch cam_data as high byte, phase <= 1.
REQ-020 CAPTURE, cam_href=1, byte phase 1: frame_pixel <= {high byte, cam_data}, frame_we <= 1 next cycle, phase <= 0, pixel count +1.
REQ-021 frame_we high exactly one cycle per pixel; frame_addr and frame_pixel stable while frame_we=1.
REQ-022 frame_addr increments by 1 on the edge ending each frame_we cycle.
REQ-023 Write at frame_addr=ADDR_LAST: executed, frame_addr holds at ADDR_LAST; all further pixels in that frame suppressed (frame_we stays 0), frame_err <= 1.
REQ-024 href rising edge: pixel count <= 0, phase <= 0.
REQ-025 href falling edge: line_cnt +1 (saturate at 255); pixel count != H_PIXELS or phase=1 -> frame_err <= 1; dangling high byte discarded.
REQ-026 CAPTURE, vsync rising edge: frame_done=1 for one cycle; line_cnt != V_LINES -> frame_err <= 1 in same edge; next state WAIT_SOF if capture_en=1, else IDLE.
REQ-027 capture_en deasserted mid-frame: current frame completes normally; no abort.
REQ-028 href and vsync edges on the same pclk: vsync edge handled, href edge still updates line_cnt before frame_err evaluation.
REQ-029 frame_err stable from frame_done until next SOF clear.
REQ-030 href activity outside CAPTURE ignored; no writes.

Reset
REQ-031 rst=1 at any time: state IDLE; frame_addr=0, frame_pixel=0, frame_we=0, frame_done=0, frame_err=0, line_cnt=0, phase=0, vsync_q=0, href_q=0.
REQ-032 rst mid-frame aborts capture; after release, capture resumes only from next vsync falling edge.

Verification
REQ-033 capture_en=1, full 320x240 frame, bytes 0xF8,0x1F per pixel -> 76800 writes, frame_pixel=0xF81F, last addr 76799, frame_done 1 cycle, frame_err=0.
REQ-034 Line 10 with 319 pixels -> frame_err=1 at frame_done; following lines still written at consecutive addresses.
REQ-035 Frame with 241 lines -> writes stop at addr 76799, frame_we=0 thereafter, frame_err=1.
REQ-036 capture_en dropped at line 100 -> frame finishes, frame_done pulses, state IDLE, next frame produces no writes.
REQ-037 rst pulse at line 50 -> all outputs 0 immediately; no writes until next vsync falling edge, then addr restarts at 0.
REQ-038 href with odd byte count (641) -> 320 writes, last byte dropped, frame_err=1.
